spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// SPI peripheral (responder) end of the SoC SPI link, mode 0 (CPOL=0, CPHA=0), MSB first.
// Oversamples external sclk/ssn/mosi in the clock_in domain, shifts one DATA_W-bit word per frame slot,
// drives miso, and exchanges words with other IP via a tx holding buffer and an rx valid/ack handshake.
// Sits on the pad side, opposite an SPI master; clock_in must be >= 4x the sclk frequency.
// PARAMETERS
// DATA_W       8   word width in bits (shift register, tx/rx data)
// SYNC_STAGES  2   flip-flop synchroniser depth for sclk_in, ssn_in, mosi_in (>= 2)
// PORTS
// clock_in     in   1       system clock; all state on posedge
// reset        in   1       asynchronous, active-high; clock clock_in
// sclk_in      in   1       SPI clock from master (asynchronous)
// ssn_in       in   1       SPI slave select, active-low (asynchronous)
// mosi_in      in   1       SPI data master->slave (asynchronous)
// miso_out     out  1       SPI data slave->master, = shift register MSB
// miso_oe      out  1       pad output enable; 1 only while selected
// tx_data      in   DATA_W  word to send in next slot
// tx_load      in   1       write tx_data into holding buffer (accepted only when tx_ready=1)
// tx_ready     out  1       holding buffer empty
// rx_data      out  DATA_W  last complete received word
// rx_valid     out  1       rx_data holds an unacknowledged word
// rx_ack       in   1       consumer took rx_data; clears rx_valid
// rx_overrun   out  1       sticky: word completed while rx_valid=1; cleared by rx_ack
// tx_underrun  out  1       sticky: slot started with empty holding buffer; cleared by tx_load
// busy         out  1       state != IDLE
// BEHAVIOUR
// - Reset values: miso_out 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, rx_overrun 0,
//   tx_underrun 0, busy 0; synchronisers reset to sclk 0, ssn 1, mosi 0; state IDLE, bit count 0.
// - Edge detect on synchronised sclk/ssn (registered previous value): event visible SYNC_STAGES+1 cycles after pin.
// - States: IDLE -> (ssn fall) LOAD -> SHIFT -> (ssn rise, any state) IDLE.
//   LOAD: single cycle; shift reg <= holding buffer, tx_ready<=1; if buffer empty shift reg <= 0, tx_underrun<=1;
//   bit count <= 0; -> SHIFT. miso_oe=1 in LOAD and SHIFT.
// - SHIFT, sclk rise: sample mosi into rx shadow LSB (shift left), bit count +1.
// - SHIFT, sclk fall: shift tx register left by 1, fill 0; miso_out = new MSB. Fall before first rise ignored.
// - Word end: on the sclk rise that makes bit count = DATA_W: rx_data <= assembled word next cycle, rx_valid<=1,
//   rx_overrun<=1 if rx_valid already 1 (rx_data still overwritten); bit count <= 0; reload shift register
//   from holding buffer on the following sclk fall (underrun rule as LOAD), so back-to-back words need no ssn toggle.
// - tx_load while tx_ready=1: buffer <= tx_data, tx_ready<=0 next cycle; tx_load while tx_ready=0 ignored.
//   tx_load in same cycle as a reload: reload takes old buffer state; new word lands in buffer.
// - rx_ack and word completion in same cycle: completion wins (rx_valid stays 1, no overrun flagged).
// - ssn rise mid-word: partial word discarded, no rx_valid, bit count 0, miso_oe 0, miso_out 0, -> IDLE;
//   holding buffer contents kept. sclk edges while IDLE ignored.
// - Bit count width clog2(DATA_W)+1; no wrap beyond DATA_W. Reset mid-frame returns all to reset values.
// TESTING
// 1. Reset, select, master clocks 0xA5 on mosi, no tx_load -> rx_data=0xA5, rx_valid=1, miso bits all 0, tx_underrun=1.
// 2. tx_load 0x3C before ssn fall, full frame -> master receives 0x3C MSB first, tx_ready=1 after LOAD, tx_underrun=0.
// 3. Two back-to-back words 0x12,0x34 in one ssn low, no rx_ack -> rx_data=0x34, rx_valid=1, rx_overrun=1; rx_ack clears both.
// 4. ssn rises after 5 sclk edges -> rx_valid stays 0, miso_oe=0, busy=0; next full frame 0x81 received correctly.
// 5. tx_load 0x55 then tx_load 0xAA while tx_ready=0 -> 0x55 transmitted; 0xAA dropped.
// 6. Assert reset mid-frame after 3 bits -> all outputs at reset values; next frame 0xF0 received intact.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first responder. The asynchronous pad
// signals are oversampled in the clock_in domain. Each slot shifts one
// DATA_W-bit word in each direction. On the transmit side the next word
// waits in a one-entry holding buffer. On the receive side a valid/ack
// handshake hands each word to the consumer.
// clock_in must run at least 4x the sclk frequency.
//
// Ports
//   clock_in    in   system clock, all state on posedge
//   reset       in   asynchronous, active-high
//   sclk_in     in   SPI clock from master (asynchronous)
//   ssn_in      in   SPI select, active-low (asynchronous)
//   mosi_in     in   SPI data master->slave (asynchronous)
//   miso_out    out  SPI data slave->master (shift register MSB)
//   miso_oe     out  pad output enable, high while selected
//   tx_data     in   word to send in the next slot
//   tx_load     in   write tx_data into the holding buffer (only when tx_ready)
//   tx_ready    out  holding buffer empty
//   rx_data     out  last complete received word
//   rx_valid    out  rx_data holds an unacknowledged word
//   rx_ack      in   consumer took rx_data
//   rx_overrun  out  sticky: word completed while rx_valid was set
//   tx_underrun out  sticky: slot started with an empty holding buffer
//   busy        out  state machine not idle
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              ssn_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ssn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ssn_prev;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift_tx;
  logic [DATA_W-1:0] r_shift_rx;
  logic              r_word_done;
  logic              r_reload_pend;
  logic              r_seen_rise;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_ready;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_overrun;
  logic              r_tx_underrun;

  logic w_sclk;
  logic w_ssn;
  logic w_mosi;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ssn_fall;
  logic w_ssn_rise;
  logic w_slot_start;
  logic w_tx_accept;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ssn       = r_ssn_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_ssn_fall  = ~w_ssn & r_ssn_prev;
  assign w_ssn_rise  = w_ssn & ~r_ssn_prev;

  // A slot starts in LOAD, or on the first qualified sclk fall after a word
  // boundary (back-to-back words within one select).
  assign w_slot_start = ~w_ssn_rise &
                        ((r_state == ST_LOAD) ||
                         ((r_state == ST_SHIFT) && w_sclk_fall && r_seen_rise && r_reload_pend));
  assign w_tx_accept  = tx_load & r_tx_ready;

  // Pad synchronisers and previous-value registers for edge detection.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ssn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ssn_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sclk_prev <= w_sclk;
      r_ssn_prev  <= w_ssn;
    end
  end

  // Frame state machine and shift registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_shift_tx    <= '0;
      r_shift_rx    <= '0;
      r_word_done   <= 1'b0;
      r_reload_pend <= 1'b0;
      r_seen_rise   <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ssn_fall) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift_tx    <= r_tx_ready ? '0 : r_tx_buf;
          r_bit_cnt     <= '0;
          r_seen_rise   <= 1'b0;
          r_reload_pend <= 1'b0;
          r_state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_sclk_rise) begin
            r_shift_rx  <= {r_shift_rx[DATA_W-2:0], w_mosi};
            r_seen_rise <= 1'b1;
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_bit_cnt     <= '0;
              r_word_done   <= 1'b1;
              r_reload_pend <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          // A fall before the first rise of the frame is ignored.
          if (w_sclk_fall && r_seen_rise) begin
            if (r_reload_pend) begin
              r_shift_tx    <= r_tx_ready ? '0 : r_tx_buf;
              r_reload_pend <= 1'b0;
            end else begin
              r_shift_tx <= {r_shift_tx[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Deselect aborts from any state; a partial word is dropped.
      if (w_ssn_rise) begin
        r_state       <= ST_IDLE;
        r_bit_cnt     <= '0;
        r_shift_tx    <= '0;
        r_word_done   <= 1'b0;
        r_reload_pend <= 1'b0;
        r_seen_rise   <= 1'b0;
      end
    end
  end

  // Transmit holding buffer. A reload in the same cycle as tx_load sees the
  // old buffer state; the new word then lands in the buffer.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_tx_buf      <= '0;
      r_tx_ready    <= 1'b1;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_slot_start && !r_tx_ready) r_tx_ready <= 1'b1;
      if (w_tx_accept) begin
        r_tx_buf      <= tx_data;
        r_tx_ready    <= 1'b0;
        r_tx_underrun <= 1'b0;
      end
      if (w_slot_start && r_tx_ready) r_tx_underrun <= 1'b1;
    end
  end

  // Receive handshake; a completing word beats a simultaneous rx_ack.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else if (r_word_done) begin
      r_rx_data  <= r_shift_rx;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !rx_ack) r_rx_overrun <= 1'b1;
      else if (rx_ack)           r_rx_overrun <= 1'b0;
    end else if (rx_ack) begin
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end
  end

  assign miso_out    = r_shift_tx[DATA_W-1];
  assign miso_oe     = (r_state != ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: a mode-0 master model with sclk at
// 1/16 of clock_in, checked against hand-computed expected values.
module tb_spi_slave;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       sclk_in  = 1'b0;
  logic       ssn_in   = 1'b1;
  logic       mosi_in  = 1'b0;
  logic       miso_out;
  logic       miso_oe;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_load  = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack   = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .sclk_in    (sclk_in),
    .ssn_in     (ssn_in),
    .mosi_in    (mosi_in),
    .miso_out   (miso_out),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic ssn_assert();
    ssn_in = 1'b0;
    #160;
  endtask

  task automatic ssn_release();
    #80;
    ssn_in = 1'b1;
    #160;
  endtask

  // One mode-0 bit: data set up, miso sampled just before the rising edge.
  task automatic xfer_bit(input logic b, output logic m);
    mosi_in = b;
    #80;
    m = miso_out;
    sclk_in = 1'b1;
    #80;
    sclk_in = 1'b0;
  endtask

  task automatic xfer_word(input logic [7:0] w, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(w[i], m);
      r[i] = m;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    #10;
    rx_ack = 1'b0;
    #10;
  endtask

  task automatic pulse_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    #10;
    tx_load = 1'b0;
    #10;
  endtask

  initial begin
    logic [7:0] r;
    logic       m;

    #25;
    @(negedge clock_in);
    check_val("rst miso_out", 32'(miso_out), 32'd0);
    check_val("rst miso_oe", 32'(miso_oe), 32'd0);
    check_val("rst tx_ready", 32'(tx_ready), 32'd1);
    check_val("rst rx_data", 32'(rx_data), 32'd0);
    check_val("rst rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst rx_overrun", 32'(rx_overrun), 32'd0);
    check_val("rst tx_underrun", 32'(tx_underrun), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #40;

    // 1: empty buffer, receive 0xA5.
    ssn_assert();
    check_val("t1 miso_oe", 32'(miso_oe), 32'd1);
    check_val("t1 busy", 32'(busy), 32'd1);
    xfer_word(8'hA5, r);
    ssn_release();
    check_val("t1 miso word", 32'(r), 32'h00);
    check_val("t1 rx_data", 32'(rx_data), 32'hA5);
    check_val("t1 rx_valid", 32'(rx_valid), 32'd1);
    check_val("t1 tx_underrun", 32'(tx_underrun), 32'd1);
    pulse_ack();
    check_val("t1 ack rx_valid", 32'(rx_valid), 32'd0);

    // 2: transmit 0x3C.
    pulse_load(8'h3C);
    check_val("t2 tx_ready loaded", 32'(tx_ready), 32'd0);
    check_val("t2 underrun cleared", 32'(tx_underrun), 32'd0);
    ssn_assert();
    check_val("t2 tx_ready after LOAD", 32'(tx_ready), 32'd1);
    check_val("t2 underrun after LOAD", 32'(tx_underrun), 32'd0);
    xfer_word(8'h69, r);
    ssn_release();
    check_val("t2 miso word", 32'(r), 32'h3C);
    check_val("t2 rx_data", 32'(rx_data), 32'h69);
    pulse_ack();

    // 3: back-to-back words, no ack between them.
    ssn_assert();
    xfer_word(8'h12, r);
    check_val("t3 first rx_data", 32'(rx_data), 32'h12);
    xfer_word(8'h34, r);
    ssn_release();
    check_val("t3 rx_data", 32'(rx_data), 32'h34);
    check_val("t3 rx_valid", 32'(rx_valid), 32'd1);
    check_val("t3 rx_overrun", 32'(rx_overrun), 32'd1);
    pulse_ack();
    check_val("t3 ack rx_valid", 32'(rx_valid), 32'd0);
    check_val("t3 ack rx_overrun", 32'(rx_overrun), 32'd0);

    // 4: abort after 5 bits, then a full frame.
    ssn_assert();
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, m);
    ssn_release();
    check_val("t4 rx_valid", 32'(rx_valid), 32'd0);
    check_val("t4 miso_oe", 32'(miso_oe), 32'd0);
    check_val("t4 busy", 32'(busy), 32'd0);
    check_val("t4 miso_out", 32'(miso_out), 32'd0);
    ssn_assert();
    xfer_word(8'h81, r);
    ssn_release();
    check_val("t4 rx_data", 32'(rx_data), 32'h81);
    check_val("t4 rx_valid full", 32'(rx_valid), 32'd1);
    pulse_ack();

    // 5: second load while buffer full is dropped.
    pulse_load(8'h55);
    pulse_load(8'hAA);
    check_val("t5 tx_ready", 32'(tx_ready), 32'd0);
    ssn_assert();
    xfer_word(8'h00, r);
    ssn_release();
    check_val("t5 miso word", 32'(r), 32'h55);
    check_val("t5 tx_ready after", 32'(tx_ready), 32'd1);
    pulse_ack();

    // 6: reset mid-frame, then a clean frame.
    pulse_load(8'hC3);
    ssn_assert();
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, m);
    reset = 1'b1;
    #20;
    check_val("t6 miso_out", 32'(miso_out), 32'd0);
    check_val("t6 miso_oe", 32'(miso_oe), 32'd0);
    check_val("t6 tx_ready", 32'(tx_ready), 32'd1);
    check_val("t6 rx_data", 32'(rx_data), 32'd0);
    check_val("t6 rx_valid", 32'(rx_valid), 32'd0);
    check_val("t6 busy", 32'(busy), 32'd0);
    check_val("t6 tx_underrun", 32'(tx_underrun), 32'd0);
    reset = 1'b0;
    #40;
    ssn_release();
    ssn_assert();
    xfer_word(8'hF0, r);
    ssn_release();
    check_val("t6 rx_data", 32'(rx_data), 32'hF0);
    check_val("t6 rx_valid after", 32'(rx_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
